// File: rtl/updown_counter.sv
// ---------------------------------------------------------------------------
// updown_counter
//
// Parametrised up/down event counter with parallel load and a choice of
// stop-at-terminal or wrap-around behaviour. A registered one-cycle `tc`
// pulse marks each terminal event. In stop mode, `done` then stays high
// until the next `go` or `rst`.
//
// Parameters
//   WIDTH    : counter width in bits (1..63)
//   MAXCOUNT : upper count bound, 1 .. 2**WIDTH-1
//   WRAP     : 0 = stop in DONE at terminal, 1 = reload start value
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   go       in   synchronous (re)start: state <- COUNT, count <- start
//   en       in   count enable (only acts in COUNT)
//   dir      in   0 = count up (0 -> MAXCOUNT), 1 = count down (MAXCOUNT -> 0)
//   load     in   synchronous parallel load of min(load_val, MAXCOUNT)
//   load_val in   value to load
//   count    out  current count, registered
//   done     out  high while in DONE (decoded from the state register)
//   tc       out  registered terminal-count pulse, one cycle wide
// ---------------------------------------------------------------------------
module updown_counter #(
    parameter int unsigned     WIDTH    = 13,
    parameter longint unsigned MAXCOUNT = (64'd1 << WIDTH) - 64'd1,
    parameter bit              WRAP     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             tc
);

    // Elaboration-time parameter legality checks.
    if (WIDTH == 0 || WIDTH > 63) begin : g_bad_width
        $error("updown_counter: WIDTH must be in 1..63");
    end
    if (MAXCOUNT == 0 || MAXCOUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_maxcount
        $error("updown_counter: MAXCOUNT must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = MAXCOUNT[WIDTH-1:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic [WIDTH-1:0] start_v;
    logic [WIDTH-1:0] load_clamped;
    logic             at_term;

    // Start value depends on the direction sampled at this edge.
    assign start_v      = dir ? MAX_V : '0;
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // A step that would leave 0..MAXCOUNT is the terminal event. The >=
    // also covers a count that somehow sits above MAXCOUNT, so the counter
    // can never walk out of range.
    assign at_term = dir ? (count == '0) : (count >= MAX_V);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count;
        tc_d    = 1'b0;
        if (go) begin
            state_d = ST_COUNT;
            count_d = start_v;
        end else if (load) begin
            count_d = load_clamped;
        end else if (state_q == ST_COUNT && en) begin
            if (at_term) begin
                tc_d = 1'b1;
                if (WRAP) begin
                    count_d = start_v;
                end else begin
                    state_d = ST_DONE;
                end
            end else if (dir) begin
                count_d = count - WIDTH'(1);
            end else begin
                count_d = count + WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so that every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count   <= '0;
            tc      <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            tc      <= tc_d;
        end
    end

    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_counter
//
// Two instances (WIDTH=4, MAXCOUNT=9), one stop-mode and one wrap-mode,
// driven by the same inputs and compared against a behavioural model of
// the counter rules. Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_updown_counter;

    localparam int W    = 4;
    localparam int MAXC = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic         en;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count0, count1;
    logic         done0, done1, tc0, tc1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(W), .MAXCOUNT(MAXC), .WRAP(1'b0)) u_stop (
        .clk(clk), .rst(rst), .go(go), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .count(count0), .done(done0), .tc(tc0)
    );

    updown_counter #(.WIDTH(W), .MAXCOUNT(MAXC), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .go(go), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .count(count1), .done(done1), .tc(tc1)
    );

    // Reference model: running = counting, finished = stopped at terminal.
    typedef struct {
        int cnt;
        bit running;
        bit finished;
        bit tc;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset();
        mdl_t r;
        r.cnt      = 0;
        r.running  = 1'b0;
        r.finished = 1'b0;
        r.tc       = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit wrap, bit g, bit e, bit d,
                                   bit l, int lv);
        mdl_t r;
        int   nxt;
        r    = m;
        r.tc = 1'b0;
        if (g) begin
            r.running  = 1'b1;
            r.finished = 1'b0;
            r.cnt      = d ? MAXC : 0;
        end else if (l) begin
            r.cnt = (lv > MAXC) ? MAXC : lv;
        end else if (m.running && e) begin
            nxt = d ? m.cnt - 1 : m.cnt + 1;
            if (nxt < 0 || nxt > MAXC) begin
                r.tc = 1'b1;
                if (wrap) begin
                    r.cnt = d ? MAXC : 0;
                end else begin
                    r.running  = 1'b0;
                    r.finished = 1'b1;
                end
            end else begin
                r.cnt = nxt;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stop_count", 32'(count0), m0.cnt);
        chk("stop_done",  32'(done0),  32'(m0.finished));
        chk("stop_tc",    32'(tc0),    32'(m0.tc));
        chk("wrap_count", 32'(count1), m1.cnt);
        chk("wrap_done",  32'(done1),  32'(m1.finished));
        chk("wrap_tc",    32'(tc1),    32'(m1.tc));
    endtask

    // Called at a falling edge: drive inputs, take one rising edge,
    // advance the model, then check at the next falling edge.
    task automatic step(input bit g, input bit e, input bit d, input bit l,
                        input int lv);
        go       = g;
        en       = e;
        dir      = d;
        load     = l;
        load_val = lv[W-1:0];
        @(posedge clk);
        m0 = mstep(m0, 1'b0, go, en, dir, load, int'(load_val));
        m1 = mstep(m1, 1'b1, go, en, dir, load, int'(load_val));
        @(negedge clk);
        check_all();
    endtask

    // Pulse rst between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        m0 = mreset();
        m1 = mreset();
        check_all();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        go       = 1'b0;
        en       = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        m0       = mreset();
        m1       = mreset();

        // Reset state.
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Stop mode, count up to 9, terminal at edge 10.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("tp1_edge0_count", 32'(count0), 0);
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp1_edge9_count", 32'(count0), 9);
        chk("tp1_edge9_tc",    32'(tc0),    0);
        chk("tp1_edge9_done",  32'(done0),  0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp1_edge10_tc",    32'(tc0),    1);
        chk("tp1_edge10_done",  32'(done0),  1);
        chk("tp1_edge10_count", 32'(count0), 9);
        chk("tp1_wrap_up_count", 32'(count1), 0);
        chk("tp1_wrap_up_tc",    32'(tc1),    1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp1_edge11_tc", 32'(tc0), 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp1_hold_count", 32'(count0), 9);
        chk("tp1_hold_done",  32'(done0),  1);

        // Wrap mode counting down: 9..0 then 9 with a tc pulse.
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        chk("tp2_start_count", 32'(count1), 9);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 0);
            chk("tp2_down_count", 32'(count1), 32'(9 - i));
            chk("tp2_down_tc",    32'(tc1),    0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        chk("tp2_wrap_count", 32'(count1), 9);
        chk("tp2_wrap_tc",    32'(tc1),    1);
        chk("tp2_wrap_done",  32'(done1),  0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        chk("tp2_after_tc",    32'(tc1),    0);
        chk("tp2_after_count", 32'(count1), 8);

        // Enable toggling from count 3 upward.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp3_base", 32'(count0), 3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp3_c4a", 32'(count0), 4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("tp3_c4b", 32'(count0), 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp3_c5a", 32'(count0), 5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("tp3_c5b", 32'(count0), 5);
        chk("tp3_tc",  32'(tc0),    0);

        // Load clamps to MAXCOUNT; load in DONE keeps DONE and freezes count.
        step(1'b0, 1'b0, 1'b0, 1'b1, 12);
        chk("tp4_clamp", 32'(count0), 9);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp4_done", 32'(done0), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5);
        chk("tp4_load_done_count", 32'(count0), 5);
        chk("tp4_load_done_done",  32'(done0),  1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp4_en_ignored", 32'(count0), 5);

        // Asynchronous reset mid-count, then IDLE ignores en until go.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp5_pre_count", 32'(count0), 6);
        async_reset();
        chk("tp5_rst_count", 32'(count0), 0);
        chk("tp5_rst_done",  32'(done0),  0);
        chk("tp5_rst_tc",    32'(tc0),    0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp5_idle_count", 32'(count0), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("tp5_restart_count", 32'(count0), 1);

        // go beats load on the same edge.
        step(1'b1, 1'b0, 1'b1, 1'b1, 7);
        chk("tp6_go_wins", 32'(count0), 9);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        chk("tp6_next", 32'(count0), 8);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit rg, re, rd, rl;
            int rv;
            if ($urandom_range(0, 49) == 0) async_reset();
            rg = ($urandom_range(0, 15) == 0);
            re = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            rl = ($urandom_range(0, 19) == 0);
            rv = int'($urandom_range(0, 15));
            step(rg, re, rd, rl, rv);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
